// File: rtl/multitap_reverb_if.sv
// Stream and tap-settings bundle for multitap_reverb.
// fb_gain is present only when MULTITAP_REVERB_FEEDBACK_EN is defined.
interface multitap_reverb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int NTAPS  = 4,
    parameter int GAIN_W = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic [NTAPS*ADDR_W-1:0]   tap_delay;
    logic [NTAPS*GAIN_W-1:0]   tap_gain;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
`ifdef MULTITAP_REVERB_FEEDBACK_EN
    logic [GAIN_W-1:0]         fb_gain;
`endif

    modport master (
`ifdef MULTITAP_REVERB_FEEDBACK_EN
        output fb_gain,
`endif
        output in_valid, in_data, tap_delay, tap_gain, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
`ifdef MULTITAP_REVERB_FEEDBACK_EN
        input  fb_gain,
`endif
        input  in_valid, in_data, tap_delay, tap_gain, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/multitap_reverb.sv
// Multi-tap reverb: one circular sample buffer, NTAPS weighted taps accumulated through one read port.
// Optional recirculating feedback into the buffer is enabled by defining MULTITAP_REVERB_FEEDBACK_EN.
module multitap_reverb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int NTAPS  = 4,
    parameter int GAIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    multitap_reverb_if.slave bus
);
    localparam int ACC_W  = DATA_W + $clog2(NTAPS + 1) + 1;
    localparam int IDX_W  = $clog2(NTAPS + 1);
    localparam int TAB    = 1 << IDX_W;
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic [PROD_W-1:0] RND = {{(PROD_W-GAIN_W+1){1'b0}}, 1'b1, {(GAIN_W-2){1'b0}}};

    typedef enum logic [1:0] {IDLE, TAP, OUT} state_t;
    state_t state_reg, state_next;

    logic [ADDR_W-1:0]        wr_ptr_reg, fill_cnt_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic [DATA_W-1:0]        dry_reg;
    logic [NTAPS*ADDR_W-1:0]  delay_reg;
    logic [NTAPS*GAIN_W-1:0]  gain_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [DATA_W-1:0]        out_data_reg;
    logic                     out_valid_reg;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DATA_W-1:0]        rd_data_reg;
    logic [GAIN_W-1:0]        rd_gain_reg;
    logic                     rd_on_reg;
`ifdef MULTITAP_REVERB_FEEDBACK_EN
    logic [GAIN_W-1:0]        fb_gain_reg;
    logic [DATA_W-1:0]        fb_wr_reg;
    logic                     fb_stage_reg;
`endif

    logic [ADDR_W-1:0]        delay_arr [TAB];
    logic [GAIN_W-1:0]        gain_arr  [TAB];
    logic [ADDR_W-1:0]        rd_addr;
    logic                     tap_on, last_tap, wr_en;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0]        wr_data;

    // Table padded to a power of two; entries past NTAPS read as delay 0 (disabled).
    genvar gi;
    generate
        for (gi = 0; gi < TAB; gi++) begin : g_tap
            if (gi < NTAPS) begin : g_used
                assign delay_arr[gi] = delay_reg[gi*ADDR_W +: ADDR_W];
                assign gain_arr[gi]  = gain_reg[gi*GAIN_W +: GAIN_W];
            end else begin : g_pad
                assign delay_arr[gi] = '0;
                assign gain_arr[gi]  = '0;
            end
        end
    endgenerate

    function automatic logic [DATA_W:0] round_mul(input logic [GAIN_W-1:0] g, input logic [DATA_W-1:0] d);
        logic [PROD_W-1:0] p;
        p = {{DATA_W{g[GAIN_W-1]}}, g} * {{GAIN_W{d[DATA_W-1]}}, d};
        p = p + RND;
        return p[PROD_W-1:GAIN_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] ext_d(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] ext_t(input logic [DATA_W:0] v);
        return {{(ACC_W-DATA_W-1){v[DATA_W]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > ACC_MAX)      return ACC_MAX[DATA_W-1:0];
        else if (v < ACC_MIN) return ACC_MIN[DATA_W-1:0];
        else                  return v[DATA_W-1:0];
    endfunction

    // Tap is live only once the buffer holds at least `delay` samples written since reset.
    always_comb begin
        rd_addr  = wr_ptr_reg - delay_arr[idx_reg];
        tap_on   = (delay_arr[idx_reg] != '0) && (fill_cnt_reg >= delay_arr[idx_reg]);
        last_tap = (idx_reg == IDX_W'(NTAPS));
        acc_sum  = acc_reg + (rd_on_reg ? ext_t(round_mul(rd_gain_reg, rd_data_reg)) : '0);
        wr_en    = (state_reg == OUT) && out_valid_reg && bus.out_ready && !rst;
    end

`ifdef MULTITAP_REVERB_FEEDBACK_EN
    assign wr_data = fb_wr_reg;
`else
    assign wr_data = dry_reg;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid) state_next = TAP;
            TAP:     if (last_tap) state_next = OUT;
            OUT:     if (out_valid_reg && bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= wr_data;
        rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            fill_cnt_reg  <= '0;
            acc_reg       <= '0;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
`ifdef MULTITAP_REVERB_FEEDBACK_EN
            fb_stage_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: if (bus.in_valid) begin
                    dry_reg   <= bus.in_data;
                    delay_reg <= bus.tap_delay;
                    gain_reg  <= bus.tap_gain;
                    acc_reg   <= ext_d(bus.in_data);
                    idx_reg   <= '0;
`ifdef MULTITAP_REVERB_FEEDBACK_EN
                    fb_gain_reg <= bus.fb_gain;
`endif
                end
                TAP: begin
                    // Read for tap idx issues now; data for tap idx-1 is accumulated now.
                    idx_reg     <= idx_reg + IDX_W'(1);
                    rd_gain_reg <= gain_arr[idx_reg];
                    rd_on_reg   <= tap_on;
                    if (idx_reg != '0) acc_reg <= acc_sum;
                    if (last_tap) begin
`ifdef MULTITAP_REVERB_FEEDBACK_EN
                        fb_stage_reg <= 1'b1;
`else
                        out_data_reg  <= sat(acc_sum);
                        out_valid_reg <= 1'b1;
`endif
                    end
                end
                OUT: begin
`ifdef MULTITAP_REVERB_FEEDBACK_EN
                    if (fb_stage_reg) begin
                        fb_stage_reg  <= 1'b0;
                        out_data_reg  <= sat(acc_reg);
                        out_valid_reg <= 1'b1;
                        fb_wr_reg     <= sat(ext_d(dry_reg) + ext_t(round_mul(fb_gain_reg, sat(acc_reg))));
                    end
`endif
                    if (out_valid_reg && bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        wr_ptr_reg    <= wr_ptr_reg + ADDR_W'(1);
                        if (fill_cnt_reg != '1) fill_cnt_reg <= fill_cnt_reg + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE) && !rst;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
endmodule
